// File: rtl/mips_mem_arbiter.sv
// Shares one sync-read memory between fetch and load/store; grant is combinational, read data returns 1 cycle later.
// Loser is backpressured by withholding gnt; data wins ties, fetch bounded by STARVE_LIMIT (ARB_ROUND_ROBIN_EN: alternate).
module mips_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_AW       = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              conflict
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  owner_t            rd_owner;
  logic [MEM_AW-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              pick_if;
  logic              unused_addr_bits;

  // Byte offset and bits above the memory window are dropped on purpose.
  assign unused_addr_bits = ^{if_addr, dm_addr};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dm;

  assign pick_if = last_dm;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       last_dm <= 1'b0;
    else if (if_gnt) last_dm <= 1'b0;
    else if (dm_gnt) last_dm <= 1'b1;
  end
`else
  logic [3:0] starve_cnt;

  assign pick_if = (starve_cnt == 4'(STARVE_LIMIT));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (if_req && !if_gnt) begin
      if (starve_cnt != 4'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end
`endif

  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!reset) begin
      if (if_req && dm_req) begin
        if_gnt = pick_if;
        dm_gnt = !pick_if;
      end else begin
        if_gnt = if_req;
        dm_gnt = dm_req;
      end
    end
  end

  // With no grant the address/data lines park on their last driven value.
  assign mem_en    = if_gnt | dm_gnt;
  assign mem_we    = dm_gnt & dm_we;
  assign mem_addr  = if_gnt ? if_addr[MEM_AW+1:2] :
                     dm_gnt ? dm_addr[MEM_AW+1:2] : addr_q;
  assign mem_wdata = dm_gnt ? dm_wdata : wdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_owner   <= OWN_NONE;
      conflict   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      addr_q   <= mem_addr;
      wdata_q  <= mem_wdata;
      conflict <= if_req & dm_req;
      if (if_gnt)                rd_owner <= OWN_IF;
      else if (dm_gnt && !dm_we) rd_owner <= OWN_DM;
      else                       rd_owner <= OWN_NONE;
      if (rd_owner == OWN_IF) if_rdata_q <= mem_rdata;
      if (rd_owner == OWN_DM) dm_rdata_q <= mem_rdata;
    end
  end

  assign if_rvalid = (rd_owner == OWN_IF);
  assign dm_rvalid = (rd_owner == OWN_DM);
  assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
  assign dm_rdata  = dm_rvalid ? mem_rdata : dm_rdata_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Randomized + directed bench for mips_mem_arbiter against a cycle-level reference model.
module tb_mips_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MEM_AW = 10;
  localparam int LIMIT  = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req = 1'b0;
  logic              dm_we = 1'b0;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic [DATA_W-1:0] dm_wdata = '0;
  logic              dm_gnt, dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en, mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              conflict;

  always #5 clock = ~clock;

  mips_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflict(conflict)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Environment memory: single port, synchronous read, write at the edge.
  logic        mem_init = 1'b1;
  logic [31:0] tb_mem [0:1023];
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) tb_mem[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state: what the arbiter owes each port, independent of RTL encoding.
  logic [31:0] ref_mem [0:1023];
  int          pend;          // 0 none, 1 fetch response due, 2 load response due
  logic [31:0] pend_data;
  logic [31:0] if_last, dm_last, prev_wdata;
  logic [9:0]  prev_addr;
  bit          prev_both;
  int          denied;        // consecutive cycles fetch asked and lost
  bit          last_dm;       // most recent grant went to data
  bit          saw_dm;

  task automatic model_reset();
    pend = 0; pend_data = '0; if_last = '0; dm_last = '0;
    prev_wdata = '0; prev_addr = '0; prev_both = 0; denied = 0; last_dm = 0;
  endtask

  task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                      input logic [31:0] da, input logic [31:0] dd);
    bit gi, gd;
    logic [9:0]  a;
    logic [31:0] wd;
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
    @(negedge clock);
    chk("if_rvalid", 32'(if_rvalid), 32'(pend == 1));
    chk("if_rdata",  if_rdata, (pend == 1) ? pend_data : if_last);
    chk("dm_rvalid", 32'(dm_rvalid), 32'(pend == 2));
    chk("dm_rdata",  dm_rdata, (pend == 2) ? pend_data : dm_last);
    chk("conflict",  32'(conflict), 32'(prev_both));
    gi = 0; gd = 0;
    if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (last_dm) gi = 1; else gd = 1;
`else
      if (denied >= LIMIT) gi = 1; else gd = 1;
`endif
    end else if (dr) gd = 1;
    else if (ir) gi = 1;
    a  = gi ? ia[11:2] : (gd ? da[11:2] : prev_addr);
    wd = gd ? dd : prev_wdata;
    chk("if_gnt",    32'(if_gnt), 32'(gi));
    chk("dm_gnt",    32'(dm_gnt), 32'(gd));
    chk("mem_en",    32'(mem_en), 32'(gi | gd));
    chk("mem_we",    32'(mem_we), 32'(gd & dw));
    chk("mem_addr",  32'(mem_addr), 32'(a));
    chk("mem_wdata", mem_wdata, wd);
    saw_dm = dm_gnt;
    if (pend == 1) if_last = pend_data;
    if (pend == 2) dm_last = pend_data;
    pend = 0;
    if (gi)              begin pend = 1; pend_data = ref_mem[a]; end
    else if (gd && !dw)  begin pend = 2; pend_data = ref_mem[a]; end
    else if (gd)         ref_mem[a] = dd;
    prev_addr = a; prev_wdata = wd; prev_both = ir & dr;
    if (ir && !gi) begin if (denied < LIMIT) denied++; end
    else denied = 0;
    if (gi) last_dm = 0;
    if (gd) last_dm = 1;
    @(posedge clock); #1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1; #1;
    model_reset();
    repeat (n) begin
      @(negedge clock);
      chk("rst_if_gnt",    32'(if_gnt), 0);
      chk("rst_dm_gnt",    32'(dm_gnt), 0);
      chk("rst_mem_en",    32'(mem_en), 0);
      chk("rst_mem_we",    32'(mem_we), 0);
      chk("rst_if_rvalid", 32'(if_rvalid), 0);
      chk("rst_dm_rvalid", 32'(dm_rvalid), 0);
      chk("rst_mem_addr",  32'(mem_addr), 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_if_rdata",  if_rdata, 0);
      chk("rst_dm_rdata",  dm_rdata, 0);
      chk("rst_conflict",  32'(conflict), 0);
      @(posedge clock); #1;
    end
    reset = 1'b0;
  endtask

  logic [9:0] seq, seq_exp;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h10; dm_addr = 32'h20;
    apply_reset(3);
    mem_init = 1'b0;

    // Fetch alone after release, then its response.
    step(1, 32'h10, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Store then load to the same word.
    step(0, 0, 1, 1, 32'h24, 32'hDEAD_BEEF);
    step(0, 0, 1, 0, 32'h24, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Fetch granted, reset lands while its response is pending.
    step(1, 32'h40, 0, 0, 0, 0);
    if_req = 1'b1; dm_req = 1'b1;
    apply_reset(2);

    // Continuous tie straight out of reset.
    seq = '0;
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h80 + 32'(i * 4), 1, 0, 32'h100 + 32'(i * 4), 0);
      seq[i] = saw_dm;
    end
`ifdef ARB_ROUND_ROBIN_EN
    seq_exp = 10'b01_0101_0101;
`else
    seq_exp = 10'b01_1110_1111;
`endif
    chk("tie_sequence", 32'(seq), 32'(seq_exp));
    step(0, 0, 0, 0, 0, 0);

    // Alternating fetch / load stream.
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) step(1, 32'(i * 4), 0, 0, 0, 0);
      else            step(0, 0, 1, 0, 32'(i * 4), 0);
    end
    step(0, 0, 0, 0, 0, 0);

    // Random traffic, upper address bits exercise the wrap.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom & 32'hF000_007F,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom & 32'hF000_007F, $urandom);
    end
    step(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
Shares one single-port, synchronous-read unified memory between the CPU instruction-fetch port and the load/store data port.
- Grants at most one access per cycle.
- Tracks the outstanding read and routes the read data back to its owner.
- Enforces a starvation bound on fetch.
- Sits between the cpu datapath (pc/fetch and load/store unit) and the unified memory; replaces the separate instruction_memory/data_memory pair.

Parameters:
ADDR_W, 32, byte-address width of both requester ports
DATA_W, 32, word width
MEM_AW, 10, word-address width driven to memory
STARVE_LIMIT, 4, max consecutive cycles fetch may be denied while requesting (1..15)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held with if_addr stable until if_gnt
if_addr  in  ADDR_W  fetch byte address
if_gnt  out  1  fetch accepted this cycle (combinational)
if_rvalid  out  1  fetch data valid (cycle after grant)
if_rdata  out  DATA_W  fetch data
dm_req  in  1  data request; held until dm_gnt
dm_we  in  1  1=store, 0=load
dm_addr  in  ADDR_W  data byte address
dm_wdata  in  DATA_W  store data
dm_gnt  out  1  data access accepted this cycle (combinational)
dm_rvalid  out  1  load data valid (cycle after load grant; never for stores)
dm_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  MEM_AW  word address = granted addr[MEM_AW+1:2]
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en && !mem_we
conflict  out  1  registered; 1 for one cycle after a cycle where both requested

Behaviour:
- Reset (async, reset=1): starve_cnt=0, rd_owner=NONE, conflict=0.
  - if_rvalid, dm_rvalid, if_gnt, dm_gnt, mem_en, mem_we = 0 for as long as reset is held.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0 for as long as reset is held.
- Arbitration is combinational within the cycle; at most one of if_gnt/dm_gnt is 1.
  - Only dm_req: grant data.
  - Only if_req: grant fetch.
  - Both: grant data, unless starve_cnt == STARVE_LIMIT, in which case grant fetch.
  - Neither: mem_en=0, mem_we=0; mem_addr and mem_wdata hold the previous cycle's values.
- Memory command follows the grant in the same cycle:
  - mem_en=1 on any grant.
  - mem_we = dm_gnt & dm_we.
  - mem_addr/mem_wdata come from the granted port.
  - Address bits [1:0] are ignored; bits above MEM_AW+1 are ignored (wrap).
- starve_cnt (registered):
  - +1 when if_req && !if_gnt.
  - Cleared on if_gnt or !if_req.
  - Saturates at STARVE_LIMIT.
- rd_owner (registered) records IF, DM or NONE for the read issued this cycle; a store or no grant records NONE.
  - Next cycle: rd_owner=IF gives if_rvalid=1, if_rdata=mem_rdata.
  - Next cycle: rd_owner=DM gives dm_rvalid=1, dm_rdata=mem_rdata.
  - The non-owner's rdata holds its last value.
- Back-to-back grants are allowed every cycle (full throughput); a new read may issue in the same cycle the previous read's rvalid is asserted.
- Store then load to the same word in consecutive cycles: the load returns the new data (the memory write occurs at the store's edge).
- Reset asserted mid-read: the pending rvalid is dropped and never asserted after reset release.
- Requester dropping req before gnt is permitted; no state is kept for it.
- conflict = registered (if_req & dm_req).

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: when both request, the arbiter alternates between them.
  - A 1-bit last_winner register is set on every grant and resets to FETCH, so data wins the first tie after reset.
  - The starve counter and STARVE_LIMIT are not used.
- Not defined: fixed data priority with the starvation bound, as specified above.

Test Plan:
1. Reset held 3 cycles with both reqs high -> all gnt/rvalid/mem_en=0. Release with if_req only, if_addr=0x10 -> if_gnt=1, mem_addr=4 same cycle; next cycle if_rvalid=1, if_rdata=preloaded word[4].
2. dm_req store addr 0x24 data 0xDEADBEEF, then load addr 0x24 next cycle -> mem_we=1 then 0; dm_rvalid one cycle after the load grant with 0xDEADBEEF; dm_rvalid never asserted for the store.
3. Both requesting continuously, STARVE_LIMIT=4 -> grant sequence D,D,D,D,F repeating; conflict=1 from the cycle after the first overlap.
4. Fetch read granted, reset pulsed on the next edge -> if_rvalid stays 0 after reset release; starve_cnt=0 (first tie after release goes to data).
5. Alternating if_req/dm_req loads every cycle, addresses 0x0,0x4,... -> one grant per cycle, each rvalid routed to the correct port with the correct word, no lost or duplicated responses.
6. ARB_ROUND_ROBIN_EN defined, both requesting continuously -> grants D,F,D,F,...; undefined -> the pattern from scenario 3.
